ms_tick_bcd_counter: RTL
========================

// Module: ms_tick_bcd_counter
// PURPOSE
//  Consumes the single-cycle 1 ms tick strobe from the tick generator and advances a
//  4-digit BCD counter every DIV ticks. Supports up/down counting, parallel load, clear,
//  wrap or stop at terminal count, and a terminal-count strobe.
//  Its count output drives the segment-load/display path.
// PARAMETERS
//  DIV         10       ticks per count step (>=1); 10 -> 10 ms resolution
//  WRAP        1        1: wrap at terminal count; 0: halt at terminal count
//  WDOG_LIMIT  100_010  clk cycles without a tick before tick_err sets (TICK_WDOG_EN only)
// PORTS
//  clk       in   1   system clock (100 MHz)
//  reset     in   1   asynchronous, active-low reset
//  tick      in   1   1-cycle strobe from the tick generator; any cycle, any spacing
//  en        in   1   count enable; level
//  up        in   1   1 = count up, 0 = count down; sampled on each step
//  load      in   1   1-cycle load request
//  load_val  in   16  BCD load value {d3,d2,d1,d0}
//  clear     in   1   1-cycle synchronous clear
//  count     out  16  BCD count {d3,d2,d1,d0}; registered
//  tc        out  1   1-cycle strobe on the cycle count wraps or reaches its halt value
//  running   out  1   1 while FSM is in RUN
//  tick_err  out  1   sticky missing-tick flag (TICK_WDOG_EN only; else constant 0)
// BEHAVIOUR
//  Reset (reset=0): count=16'h0000, tc=0, running=0, tick_err=0, prescaler=0, FSM=IDLE.
//   Applies immediately and asynchronously, including mid-step.
//  FSM states:
//   IDLE: en=1 -> RUN
//   RUN: en=0 -> IDLE; step reaches terminal count with WRAP=0 -> HALT
//   HALT: load or clear -> IDLE, or RUN if en=1. Ticks are ignored in HALT.
//  Prescaler, 0..DIV-1: in RUN, tick with prescaler==DIV-1 is a step and resets the
//   prescaler to 0; any other tick increments it. In IDLE the prescaler holds.
//  Step latency: count and tc update on the clk edge after the qualifying tick is sampled
//   (1 cycle).
//  BCD arithmetic, per digit with ripple carry/borrow:
//   up: 9 -> 0 carries into next digit.
//   down: 0 -> 9 borrows from next digit.
//  Terminal count: up 9999 -> 0000, down 0000 -> 9999.
//   WRAP=1: count wraps, tc=1 for one cycle.
//   WRAP=0: count stays at 9999 (up) / 0000 (down), tc=1 for one cycle, FSM -> HALT.
//   Further ticks produce no additional tc.
//  Priority, same cycle: clear > load > step.
//   clear: count=0000, prescaler=0.
//   load: count=load_val, prescaler=0.
//   A step coincident with load or clear is discarded; tc=0 that cycle.
//  Invalid BCD on load: any load_val digit >9 is stored as 9. Example: 16'h12A4 -> 16'h1294.
//  Changing direction (up) mid-run takes effect at the next step; the prescaler is kept.
//  A tick on the same cycle en rises is counted; a tick on the same cycle en falls is not.
// CONFIGURATION
//  TICK_WDOG_EN defined:
//   Cycle counter is cleared on every tick and on clear.
//   While en=1 and FSM != HALT, the counter increments each clk.
//   Reaching WDOG_LIMIT sets tick_err, which stays set until clear or reset.
//   Counting is unaffected.
//  TICK_WDOG_EN undefined: no watchdog logic; tick_err tied to 0.
// TESTING
//  DIV=10, en=1, up=1, 10 ticks at 1 ms spacing from reset -> count=0001 1 cycle after
//   10th tick, tc never 1.
//  load 9998, up=1, 20 ticks, WRAP=1 -> count 9999 then 0000; tc high exactly 1 cycle
//   at 0000.
//  WRAP=0, load 0001, up=0, 20 ticks -> 0000, tc 1 cycle, running=0; 30 more ticks ->
//   count stays 0000, no tc.
//  load and clear same cycle as 10th tick -> count=0000; next step needs 10 fresh ticks.
//  load_val=16'h12A4 -> count=16'h1294. reset low mid-run -> all outputs 0 immediately.
//  TICK_WDOG_EN, en=1, no tick for WDOG_LIMIT cycles -> tick_err=1; clear -> tick_err=0.

Source files
------------

// File: rtl/ms_tick_bcd_counter.sv
// ms_tick_bcd_counter
//   Advances a 4-digit BCD counter once every DIV pulses of the 1 ms tick strobe.
//   Counts up or down. Supports parallel load, synchronous clear, and either wrap or
//   halt at terminal count. Emits a one-cycle terminal-count strobe.
//   The count output feeds the segment-load/display path.
//
//   Optional feature macro: TICK_WDOG_EN. When defined, a missing-tick watchdog drives
//   tick_err. When undefined, tick_err is tied to 0.
//
// Parameters
//   DIV         ticks per count step (>= 1)
//   WRAP        1: wrap at terminal count, 0: halt there
//   WDOG_LIMIT  clk cycles without a tick before tick_err sets (watchdog builds only)
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous active-low reset
//   tick      in   1-cycle tick strobe
//   en        in   count enable (level)
//   up        in   1 = count up, 0 = count down
//   load      in   1-cycle load request, takes load_val
//   load_val  in   BCD load value {d3,d2,d1,d0}; digits above 9 are stored as 9
//   clear     in   1-cycle synchronous clear (beats load, which beats a step)
//   count     out  registered BCD count
//   tc        out  1-cycle strobe when a step wraps or reaches the halt value
//   running   out  1 while the FSM is in RUN
//   tick_err  out  sticky missing-tick flag
module ms_tick_bcd_counter #(
   parameter int unsigned DIV        = 10,
   parameter bit          WRAP       = 1'b1,
   parameter int unsigned WDOG_LIMIT = 100_010
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        tick,
   input  logic        en,
   input  logic        up,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        clear,
   output logic [15:0] count,
   output logic        tc,
   output logic        running,
   output logic        tick_err
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   state_t        state, state_next;
   logic [PW-1:0] presc;
   logic          active;
   logic          tick_cnt;
   logic          step;
   logic          terminal;
   logic          halt_step;

   // One BCD step with ripple carry (up) or borrow (down). 9999+1 gives 0000 and
   // 0000-1 gives 9999, so wrap needs no special case.
   function automatic logic [15:0] bcd_step(input logic [15:0] v, input logic dir_up);
      logic [15:0] r;
      logic        c;
      r = v;
      c = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (c) begin
            if (dir_up) begin
               if (v[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
               else begin
                  r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                  c = 1'b0;
               end
            end else begin
               if (v[i*4 +: 4] == 4'd0) r[i*4 +: 4] = 4'd9;
               else begin
                  r[i*4 +: 4] = v[i*4 +: 4] - 4'd1;
                  c = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

   // Saturate any non-decimal digit to 9.
   function automatic logic [15:0] bcd_clamp(input logic [15:0] v);
      logic [15:0] r;
      for (int i = 0; i < 4; i++)
         r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
      return r;
   endfunction

   // Ticks count whenever en is high outside HALT. Using en directly, not the state,
   // counts a tick on the cycle en rises and drops a tick on the cycle en falls.
   assign active    = en && (state != HALT);
   assign tick_cnt  = active && tick;
   assign step      = tick_cnt && (presc == PRESC_MAX) && !load && !clear;
   assign terminal  = up ? (count == 16'h9999) : (count == 16'h0000);
   assign halt_step = step && terminal && !WRAP;

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of process order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      // NOTE: default assignment first so no path through the case infers a latch.
      state_next = state;
      unique case (state)
         IDLE:    if (halt_step) state_next = HALT;
                  else if (en)   state_next = RUN;
         RUN:     if (halt_step) state_next = HALT;
                  else if (!en)  state_next = IDLE;
         HALT:    if (clear || load) state_next = en ? RUN : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      running = (state == RUN);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= 16'h0000;
         tc    <= 1'b0;
         presc <= '0;
      end else begin
         tc <= step && terminal;

         if (clear)
            count <= 16'h0000;
         else if (load)
            count <= bcd_clamp(load_val);
         else if (step && !(terminal && !WRAP))
            count <= bcd_step(count, up);

         if (clear || load)
            presc <= '0;
         else if (tick_cnt)
            presc <= (presc == PRESC_MAX) ? '0 : presc + PW'(1);
      end
   end

`ifdef TICK_WDOG_EN
   localparam int unsigned WW = $clog2(WDOG_LIMIT + 1);
   localparam logic [WW-1:0] WD_MAX = WW'(WDOG_LIMIT);

   logic [WW-1:0] wdog_cnt;
   logic          wdog_inc;

   assign wdog_inc = en && (state != HALT) && !tick && !clear;

   // The counter saturates at the limit so it cannot roll over and hide a long gap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wdog_cnt <= '0;
         tick_err <= 1'b0;
      end else begin
         if (tick || clear)
            wdog_cnt <= '0;
         else if (wdog_inc && (wdog_cnt != WD_MAX))
            wdog_cnt <= wdog_cnt + WW'(1);

         if (clear)
            tick_err <= 1'b0;
         else if (wdog_inc && (wdog_cnt == WD_MAX - WW'(1)))
            tick_err <= 1'b1;
      end
   end
`else
   assign tick_err = 1'b0;
`endif

endmodule
